// File: rtl/host_packet_streamer_pkg.sv
// Shared types and constants for the host packet streamer.
package host_stream_pkg;

    localparam int HDR_BYTES    = 3;
    localparam int MATCH_CODE_W = 8;
    localparam int DROP_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/host_packet_streamer_if.sv
// Host-side byte stream (valid/ready with last marker).
interface host_stream_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/host_packet_streamer_skid.sv
// Two-entry (data, last) buffer that soaks up the one-cycle packet buffer read latency.
module host_skid_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [1:0] count
);
    logic [8:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q][7:0];
    assign out_last  = mem_q[rd_ptr_q][8];
    assign count     = count_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    mem_q[gi] <= {in_last, in_data};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/host_packet_streamer.sv
// Streams a completed packet (3-byte header + payload) from the packet buffer to the host.
// Build option: HOST_STREAMER_DROP_UNMATCHED_EN releases match_code==0 packets without streaming them.
module host_packet_streamer
    import host_stream_pkg::*;
#(
    parameter int MAX_PACKET_LEN = 1500,
    parameter int ADDR_W         = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    match_valid,
    input  logic [MATCH_CODE_W-1:0] match_code,
    input  logic [ADDR_W-1:0]       pkt_len,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_en,
    input  logic [7:0]              rd_data,
    output logic                    buf_release,
    output logic                    busy,
    host_stream_if.master           m,
    output logic [DROP_CNT_W-1:0]   drop_count
);
`ifdef HOST_STREAMER_DROP_UNMATCHED_EN
    localparam bit DROP_UNMATCHED = 1'b1;
`else
    localparam bit DROP_UNMATCHED = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] MAX_LEN  = ADDR_W'(MAX_PACKET_LEN);
    localparam logic [1:0]        HDR_LAST = 2'(HDR_BYTES - 1);

    state_e                  state_q, state_d;
    logic [MATCH_CODE_W-1:0] code_q, code_d;
    logic [ADDR_W-1:0]       len_q, len_d;
    logic [1:0]              hdr_idx_q, hdr_idx_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    rd_done_q, rd_done_d;
    logic                    rd_inflight_q;
    logic                    rd_last_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0] len_clamped;
    logic              rd_issue;
    logic              rd_is_last;
    logic [2:0]        credit_used;
    logic              fifo_in_ready;
    logic              fifo_out_valid;
    logic              fifo_out_ready;
    logic [7:0]        fifo_out_data;
    logic              fifo_out_last;
    logic [1:0]        fifo_count;
    logic              pay_pop;
    logic [7:0]        tdata_c;
    logic              tvalid_c;
    logic              tlast_c;

    assign len_clamped = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
    assign pay_pop     = fifo_out_valid && fifo_out_ready;
    assign credit_used = {1'b0, fifo_count} + {2'b0, rd_inflight_q};
    assign rd_is_last  = (rd_addr_q == len_q - 1'b1);

    // A read may issue if its data will find a slot one cycle later, counting this cycle's pop.
    assign rd_issue = ((state_q == HDR) || (state_q == PAYLOAD)) && !rd_done_q
                      && (credit_used < (3'd2 + {2'b0, pay_pop}));

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        len_d          = len_q;
        hdr_idx_d      = hdr_idx_q;
        rd_addr_d      = rd_addr_q;
        rd_done_d      = rd_done_q;
        drop_cnt_d     = drop_cnt_q;
        tdata_c        = '0;
        tvalid_c       = 1'b0;
        tlast_c        = 1'b0;
        fifo_out_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (match_valid) begin
                    code_d    = match_code;
                    len_d     = len_clamped;
                    hdr_idx_d = '0;
                    rd_addr_d = '0;
                    rd_done_d = (len_clamped == '0);
                    if (DROP_UNMATCHED && (match_code == '0)) begin
                        state_d    = DONE;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                tvalid_c = 1'b1;
                case (hdr_idx_q)
                    2'd0:    tdata_c = code_q;
                    2'd1:    tdata_c = 8'(len_q >> 8);
                    default: tdata_c = len_q[7:0];
                endcase
                tlast_c = (hdr_idx_q == HDR_LAST) && (len_q == '0);
                if (m.m_tready) begin
                    if (hdr_idx_q == HDR_LAST) begin
                        state_d = (len_q == '0) ? DONE : PAYLOAD;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            PAYLOAD: begin
                fifo_out_ready = m.m_tready;
                tvalid_c       = fifo_out_valid;
                tdata_c        = fifo_out_data;
                tlast_c        = fifo_out_valid && fifo_out_last;
                if (pay_pop && fifo_out_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (match_valid && (state_q != IDLE)) drop_cnt_d = sat_inc(drop_cnt_q);

        if (rd_issue) begin
            if (rd_is_last) rd_done_d = 1'b1;
            else            rd_addr_d = rd_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            code_q        <= '0;
            len_q         <= '0;
            hdr_idx_q     <= '0;
            rd_addr_q     <= '0;
            rd_done_q     <= 1'b1;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            len_q         <= len_d;
            hdr_idx_q     <= hdr_idx_d;
            rd_addr_q     <= rd_addr_d;
            rd_done_q     <= rd_done_d;
            rd_inflight_q <= rd_issue;
            rd_last_q     <= rd_issue && rd_is_last;
            drop_cnt_q    <= drop_cnt_d;
            assert (!rd_inflight_q || fifo_in_ready);
        end
    end

    host_skid_fifo u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_inflight_q),
        .in_ready  (fifo_in_ready),
        .in_data   (rd_data),
        .in_last   (rd_last_q),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_out_ready),
        .out_data  (fifo_out_data),
        .out_last  (fifo_out_last),
        .count     (fifo_count)
    );

    assign rd_en       = rd_issue;
    assign rd_addr     = rd_addr_q;
    assign buf_release = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign drop_count  = drop_cnt_q;
    assign m.m_tdata   = tdata_c;
    assign m.m_tvalid  = tvalid_c;
    assign m.m_tlast   = tlast_c;
endmodule

// File: tb/tb_host_packet_streamer.sv
// Directed bench for host_packet_streamer: framing, backpressure, drops, reset and release timing.
module tb_host_packet_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        match_valid;
    logic [7:0]  match_code;
    logic [10:0] pkt_len;
    logic [10:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        buf_release;
    logic        busy;
    logic [15:0] drop_count;

    host_stream_if hs ();

    host_packet_streamer #(.MAX_PACKET_LEN(1500), .ADDR_W(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .match_valid (match_valid),
        .match_code  (match_code),
        .pkt_len     (pkt_len),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .buf_release (buf_release),
        .busy        (busy),
        .m           (hs),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:2047];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int checks = 0;
    int failures = 0;
    int exp_drop = 0;

    logic [7:0] got_data [$];
    bit         got_last [$];
    int         n_cyc, stall_err, rd_cnt;
    bit         timed_out;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] code, input int len, input int i);
        if (i == 0) return code;
        if (i == 1) return 8'(len >> 8);
        if (i == 2) return 8'(len);
        return mem[i-3];
    endfunction

    task automatic start(input logic [7:0] code, input int len);
        match_valid = 1'b1;
        match_code  = code;
        pkt_len     = 11'(len);
        step();
        match_valid = 1'b0;
    endtask

    // Gathers transferred beats until tlast; optionally pulses match_valid at one cycle offset.
    task automatic collect(input int inject_at, input bit rand_ready, input int max_cycles);
        bit         done = 0;
        bit         prev_stall = 0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        got_data.delete();
        got_last.delete();
        n_cyc = 0; stall_err = 0; rd_cnt = 0; timed_out = 0;
        while (!done) begin
            if (n_cyc >= max_cycles) begin
                timed_out = 1;
                break;
            end
            hs.m_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            match_valid = (n_cyc == inject_at);
            match_code  = 8'h5A;
            pkt_len     = 11'd7;
            #1;
            if (prev_stall && (hs.m_tvalid !== 1'b1 || hs.m_tdata !== pd || hs.m_tlast !== pl))
                stall_err++;
            if (rd_en === 1'b1) rd_cnt++;
            if (hs.m_tvalid && hs.m_tready) begin
                got_data.push_back(hs.m_tdata);
                got_last.push_back(hs.m_tlast);
                if (hs.m_tlast) done = 1;
            end
            prev_stall = hs.m_tvalid && !hs.m_tready;
            pd = hs.m_tdata;
            pl = hs.m_tlast;
            n_cyc++;
            step();
        end
        match_valid = 1'b0;
        hs.m_tready = 1'b1;
        $display("frame beats=%0d cycles=%0d reads=%0d drops=%0d", got_data.size(), n_cyc, rd_cnt, drop_count);
    endtask

    task automatic test_reset();
        rst = 1'b1; match_valid = 1'b0; match_code = '0; pkt_len = '0; hs.m_tready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if ({hs.m_tvalid, hs.m_tlast, hs.m_tdata, rd_en, rd_addr, buf_release, busy, drop_count} !== '0) begin
            failures++;
            $display("FAIL reset_state got tv=%0b tl=%0b td=%02h rd=%0b ra=%0d rel=%0b busy=%0b drop=%0d exp all zero",
                     hs.m_tvalid, hs.m_tlast, hs.m_tdata, rd_en, rd_addr, buf_release, busy, drop_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [7];
        exp = '{8'h02, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start(8'h02, 4);
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 11'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_read got rd_en=%0b addr=%0d busy=%0b exp 1/0/1", rd_en, rd_addr, busy);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (hs.m_tvalid !== 1'b1 || hs.m_tdata !== exp[i] || hs.m_tlast !== (i == 6)) begin
                failures++;
                $display("FAIL basic_beat%0d got v=%0b d=%02h l=%0b exp v=1 d=%02h l=%0b",
                         i, hs.m_tvalid, hs.m_tdata, hs.m_tlast, exp[i], (i == 6));
            end
            step();
        end
        checks++;
        if (buf_release !== 1'b1 || busy !== 1'b1 || hs.m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got rel=%0b busy=%0b tv=%0b exp 1/1/0", buf_release, busy, hs.m_tvalid);
        end
        step();
        checks++;
        if (buf_release !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got rel=%0b busy=%0b exp 0/0", buf_release, busy);
        end
        $display("frame code=02 len=4 beats=7");
    endtask

    task automatic test_zero_len();
        start(8'h03, 0);
        collect(-1, 1'b0, 20);
        checks++;
        if (timed_out || got_data.size() != 3 || n_cyc != 3 || rd_cnt != 0) begin
            failures++;
            $display("FAIL zero_len_shape got beats=%0d cycles=%0d reads=%0d to=%0b exp 3/3/0/0",
                     got_data.size(), n_cyc, rd_cnt, timed_out);
        end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h03, 0, i) || got_last[i] !== (i == 2)) begin
                failures++;
                $display("FAIL zero_len_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h03, 0, i), (i == 2));
            end
        end
        checks++;
        if (buf_release !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_release got %0b exp 1", buf_release);
        end
        step();
    endtask

    task automatic test_back_to_back();
        start(8'h01, 2);
        collect(-1, 1'b0, 20);
        checks++;
        if (buf_release !== 1'b1 || got_data.size() != 5) begin
            failures++;
            $display("FAIL b2b_first got rel=%0b beats=%0d exp 1/5", buf_release, got_data.size());
        end
        start(8'h04, 9);
        exp_drop++;
        checks++;
        if (busy !== 1'b0 || drop_count !== 16'(exp_drop)) begin
            failures++;
            $display("FAIL b2b_done_drop got busy=%0b drop=%0d exp 0/%0d", busy, drop_count, exp_drop);
        end
        start(8'h01, 3);
        checks++;
        if (busy !== 1'b1 || hs.m_tdata !== 8'h01) begin
            failures++;
            $display("FAIL b2b_accept got busy=%0b td=%02h exp 1/01", busy, hs.m_tdata);
        end
        collect(-1, 1'b0, 20);
        checks++;
        if (timed_out || got_data.size() != 6 || n_cyc != 6) begin
            failures++;
            $display("FAIL b2b_second_shape got beats=%0d cycles=%0d exp 6/6", got_data.size(), n_cyc);
        end
        for (int i = 0; i < got_data.size() && i < 6; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h01, 3, i) || got_last[i] !== (i == 5)) begin
                failures++;
                $display("FAIL b2b_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h01, 3, i), (i == 5));
            end
        end
        step();
    endtask

    task automatic test_clamp();
        start(8'h02, 2000);
        collect(-1, 1'b0, 3000);
        checks++;
        if (timed_out || got_data.size() != 1503 || n_cyc != 1503 || rd_cnt != 1500) begin
            failures++;
            $display("FAIL clamp_shape got beats=%0d cycles=%0d reads=%0d exp 1503/1503/1500",
                     got_data.size(), n_cyc, rd_cnt);
        end
        for (int i = 0; i < got_data.size() && i < 1503; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h02, 1500, i) || got_last[i] !== (i == 1502)) begin
                failures++;
                $display("FAIL clamp_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h02, 1500, i), (i == 1502));
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        start(8'h01, 261);
        collect(-1, 1'b1, 3000);
        checks++;
        if (timed_out || got_data.size() != 264 || stall_err != 0 || rd_cnt != 261) begin
            failures++;
            $display("FAIL bp_shape got beats=%0d stall_err=%0d reads=%0d to=%0b exp 264/0/261/0",
                     got_data.size(), stall_err, rd_cnt, timed_out);
        end
        for (int i = 0; i < got_data.size() && i < 264; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h01, 261, i) || got_last[i] !== (i == 263)) begin
                failures++;
                $display("FAIL bp_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h01, 261, i), (i == 263));
            end
        end
        step();
    endtask

    task automatic test_unmatched();
        start(8'h00, 10);
`ifdef HOST_STREAMER_DROP_UNMATCHED_EN
        exp_drop++;
        checks++;
        if (hs.m_tvalid !== 1'b0 || buf_release !== 1'b1 || busy !== 1'b1 || drop_count !== 16'(exp_drop)) begin
            failures++;
            $display("FAIL unmatched_drop got tv=%0b rel=%0b busy=%0b drop=%0d exp 0/1/1/%0d",
                     hs.m_tvalid, buf_release, busy, drop_count, exp_drop);
        end
        step();
        checks++;
        if (busy !== 1'b0 || buf_release !== 1'b0 || hs.m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL unmatched_idle got busy=%0b rel=%0b tv=%0b exp 0/0/0", busy, buf_release, hs.m_tvalid);
        end
`else
        collect(-1, 1'b0, 40);
        checks++;
        if (timed_out || got_data.size() != 13 || n_cyc != 13 || drop_count !== 16'(exp_drop)) begin
            failures++;
            $display("FAIL unmatched_shape got beats=%0d cycles=%0d drop=%0d exp 13/13/%0d",
                     got_data.size(), n_cyc, drop_count, exp_drop);
        end
        for (int i = 0; i < got_data.size() && i < 13; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h00, 10, i) || got_last[i] !== (i == 12)) begin
                failures++;
                $display("FAIL unmatched_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h00, 10, i), (i == 12));
            end
        end
        step();
`endif
    endtask

    task automatic test_drop();
        start(8'h02, 6);
        collect(5, 1'b0, 30);
        exp_drop++;
        checks++;
        if (timed_out || got_data.size() != 9 || drop_count !== 16'(exp_drop)) begin
            failures++;
            $display("FAIL drop_payload got beats=%0d drop=%0d exp 9/%0d", got_data.size(), drop_count, exp_drop);
        end
        for (int i = 0; i < got_data.size() && i < 9; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h02, 6, i) || got_last[i] !== (i == 8)) begin
                failures++;
                $display("FAIL drop_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h02, 6, i), (i == 8));
            end
        end
        step();
        // Hold a frame stalled on its first header beat while drops accumulate.
        hs.m_tready = 1'b0;
        start(8'h04, 8);
        match_valid = 1'b1;
        repeat (65534 - exp_drop) step();
        checks++;
        if (drop_count !== 16'hFFFE || hs.m_tdata !== 8'h04 || hs.m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL drop_near_sat got drop=%04h td=%02h tv=%0b exp FFFE/04/1", drop_count, hs.m_tdata, hs.m_tvalid);
        end
        repeat (3) step();
        match_valid = 1'b0;
        checks++;
        if (drop_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL drop_saturate got %04h exp FFFF", drop_count);
        end
        collect(-1, 1'b0, 30);
        checks++;
        if (timed_out || got_data.size() != 11 || got_data[0] !== 8'h04 || got_data[10] !== mem[7]) begin
            failures++;
            $display("FAIL drop_frame_intact got beats=%0d to=%0b exp 11/0", got_data.size(), timed_out);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        start(8'h02, 20);
        repeat (6) step();
        rst = 1'b1;
        step();
        checks++;
        if ({hs.m_tvalid, hs.m_tlast, hs.m_tdata, rd_en, rd_addr, buf_release, busy, drop_count} !== '0) begin
            failures++;
            $display("FAIL midreset_state got tv=%0b tl=%0b td=%02h rd=%0b ra=%0d rel=%0b busy=%0b drop=%0d exp all zero",
                     hs.m_tvalid, hs.m_tlast, hs.m_tdata, rd_en, rd_addr, buf_release, busy, drop_count);
        end
        rst = 1'b0;
        exp_drop = 0;
        step();
        start(8'h02, 4);
        collect(-1, 1'b0, 20);
        checks++;
        if (timed_out || got_data.size() != 7 || n_cyc != 7 || rd_cnt != 4) begin
            failures++;
            $display("FAIL midreset_shape got beats=%0d cycles=%0d reads=%0d exp 7/7/4", got_data.size(), n_cyc, rd_cnt);
        end
        for (int i = 0; i < got_data.size() && i < 7; i++) begin
            checks++;
            if (got_data[i] !== exp_byte(8'h02, 4, i) || got_last[i] !== (i == 6)) begin
                failures++;
                $display("FAIL midreset_beat%0d got %02h/%0b exp %02h/%0b", i, got_data[i], got_last[i],
                         exp_byte(8'h02, 4, i), (i == 6));
            end
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 13 + 7) ^ 8'(i >> 8);
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        test_reset();
        test_basic();
        test_zero_len();
        test_back_to_back();
        test_clamp();
        test_backpressure();
        test_unmatched();
        test_drop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/host_packet_streamer.md
# host_packet_streamer

Downstream stage of the pattern detector. It takes the 8-bit match code and the packet length for a completed packet, reads that packet byte by byte out of the receive packet buffer, and streams it to the host interface. Each frame carries a 3-byte header followed by the payload. When the whole frame has been accepted by the host, the block releases the buffer back to the receive side.

## Interface
- MAX_PACKET_LEN, 1500: packet buffer depth in bytes; the largest payload streamed.
- ADDR_W, 11: width of the buffer address and of the length fields.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- match_valid  in  1  one-cycle pulse: match_code and pkt_len are valid.
- match_code  in  8  code from the pattern detector (0 = no match, 1..4 = pattern index).
- pkt_len  in  ADDR_W  payload length in bytes (the byte_count of the packet).
- rd_addr  out  ADDR_W  packet buffer read address.
- rd_en  out  1  read strobe; rd_data is valid exactly 1 cycle after rd_en.
- rd_data  in  8  packet buffer read data.
- buf_release  out  1  one-cycle pulse: the buffer may be overwritten.
- busy  out  1  high from acceptance of a packet until its buf_release, inclusive.
- m_tdata  out  8  host stream byte.
- m_tvalid  out  1  host stream valid.
- m_tready  in  1  host stream ready.
- m_tlast  out  1  marks the final byte of the frame.
- drop_count  out  16  saturating count of dropped packets.

## Operation
- Frame layout: byte0 = match_code, byte1 = {5'b0, len[10:8]}, byte2 = len[7:0], then payload bytes at buffer addresses 0..len-1.
- len = min(pkt_len, MAX_PACKET_LEN).
- len = 0 gives a header-only frame; m_tlast is on byte2.
- FSM states: IDLE, HDR, PAYLOAD, DONE.
  - IDLE -> HDR on match_valid.
  - HDR emits 3 header beats -> PAYLOAD (or -> DONE when len = 0).
  - PAYLOAD ends with the tlast handshake -> DONE.
  - DONE pulses buf_release -> IDLE.
- Handshake rules on the host stream:
  - A beat transfers when m_tvalid && m_tready.
  - Once m_tvalid is high, m_tdata and m_tlast hold stable until the transfer.
  - m_tvalid never drops without a transfer, except on rst.
- Reads: rd_addr counts 0..len-1. A read is issued only when the 2-entry skid buffer has a free slot after counting the read already in flight. Read data is never lost under backpressure.
- Drops: a match_valid seen in any state other than IDLE is ignored and drop_count increments. The in-flight frame is unaffected.
- drop_count saturates at 0xFFFF.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, rd_en=0, rd_addr=0, buf_release=0, busy=0, drop_count=0, FSM=IDLE, skid buffer empty.
- Reset mid-frame: the frame is abandoned with no tlast. The next frame starts clean after reset.

## Timing
- match_valid at cycle T: busy=1 and m_tvalid=1 with byte0 at T+1.
- With m_tready held high: one beat per cycle, no bubbles. The frame occupies T+1..T+3+len.
- buf_release pulses one cycle after the tlast transfer. busy falls the cycle after that.
- The earliest accepted next match_valid is the cycle after buf_release.
- Backpressure: a deassert/reassert of m_tready at any beat adds exactly the stalled cycles and no extra bubble.
- First payload read: rd_en is first asserted at T+1, so payload byte0 is available in time for beat 4.

## Configuration
- HOST_STREAMER_DROP_UNMATCHED_EN defined:
  - A packet with match_code==0 is not streamed.
  - The FSM goes IDLE -> DONE, so buf_release pulses at T+1 and busy is high for that cycle only.
  - drop_count increments.
- HOST_STREAMER_DROP_UNMATCHED_EN undefined: code 0 packets are streamed like any other.

## Structure
- Package host_stream_pkg holds:
  - the state enum;
  - HDR_BYTES=3;
  - MATCH_CODE_W=8;
  - DROP_CNT_W=16.
- One sub-module: host_skid_fifo, a 2-entry 8+1-bit (data, last) buffer with valid/ready on both sides. It absorbs the 1-cycle read latency under backpressure.

## Test plan
- match_code=2, pkt_len=4, buffer bytes AA BB CC DD, m_tready=1 -> beats 02 00 04 AA BB CC DD on consecutive cycles; tlast on DD; buf_release 1 cycle later.
- pkt_len=0x105, m_tready toggled randomly -> header 01 05, then 261 payload bytes in order; no byte lost or duplicated; m_tdata stable while stalled.
- match_valid during PAYLOAD -> current frame intact, drop_count=1; after 0xFFFF + 2 such drops, drop_count=0xFFFF.
- pkt_len=0, code 3 -> 03 00 00 with tlast on the third beat; buf_release follows.
- rst asserted mid-payload -> next cycle all outputs at reset values; a following packet streams correctly.
- With HOST_STREAMER_DROP_UNMATCHED_EN: code 0, len 10 -> no m_tvalid, buf_release at T+1, drop_count=1. Without the macro: full 13-beat frame.
